sha256_core: RTL and testbench

SHA256_CORE -- requirements
Module: sha256_core

---
 rtl/sha256_pkg.sv | 81 ++++++++
 rtl/sha256_round.sv | 40 ++++
 rtl/sha256_core.sv | 127 ++++++++++++
 tb/tb_sha256_core.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, the
// compression helper functions and the core FSM state type.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HASH_W = 256;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    FINAL   = 2'd2
  } state_t;

  // Working variables a..h, a in the most significant word to match H0..H7.
  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] e;
    logic [WORD_W-1:0] f;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] h;
  } work_t;

  localparam logic [HASH_W-1:0] H_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x,
                                           input logic [WORD_W-1:0] y,
                                           input logic [WORD_W-1:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x,
                                            input logic [WORD_W-1:0] y,
                                            input logic [WORD_W-1:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: a..h in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] a_nxt_c,
  output logic [31:0] b_nxt_c,
  output logic [31:0] c_nxt_c,
  output logic [31:0] d_nxt_c,
  output logic [31:0] e_nxt_c,
  output logic [31:0] f_nxt_c,
  output logic [31:0] g_nxt_c,
  output logic [31:0] h_nxt_c
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign a_nxt_c = t1 + t2;
  assign b_nxt_c = a;
  assign c_nxt_c = b;
  assign d_nxt_c = c;
  assign e_nxt_c = d + t1;
  assign f_nxt_c = e;
  assign g_nxt_c = f;
  assign h_nxt_c = g;

endmodule

// File: rtl/sha256_core.sv
// SHA-256 block core: loads 16 pre-padded words, compresses, chains H.
// SHA256_CORE_TWO_ROUNDS_EN selects two chained rounds per clock.
module sha256_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic [31:0]  data,
  input  logic         wr_en,
  output logic         wr_ready,
  output logic         blk_ready,
  output logic [255:0] hash
);

`ifdef SHA256_CORE_TWO_ROUNDS_EN
  localparam int unsigned ROUND_STEP = 2;
`else
  localparam int unsigned ROUND_STEP = 1;
`endif
  localparam logic [5:0] LAST_RND = 6'(64 - ROUND_STEP);

  state_t      state;
  logic [3:0]  word_cnt;
  logic [5:0]  rnd;
  logic [31:0] w     [16];
  logic [31:0] w_nxt [16];
  work_t       wk;
  work_t       wk_nxt;
  work_t       r0;
  logic [31:0] w16_c;
  logic [255:0] h_sum;

  // w[0] always holds W[t] for the current round; the window slides each round.
  assign w16_c = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

  sha256_round u_round0 (
    .a(wk.a), .b(wk.b), .c(wk.c), .d(wk.d),
    .e(wk.e), .f(wk.f), .g(wk.g), .h(wk.h),
    .k(K[rnd]), .w(w[0]),
    .a_nxt_c(r0.a), .b_nxt_c(r0.b), .c_nxt_c(r0.c), .d_nxt_c(r0.d),
    .e_nxt_c(r0.e), .f_nxt_c(r0.f), .g_nxt_c(r0.g), .h_nxt_c(r0.h)
  );

`ifdef SHA256_CORE_TWO_ROUNDS_EN
  work_t       r1;
  logic [31:0] w17_c;

  assign w17_c = small_sigma1(w[15]) + w[10] + small_sigma0(w[2]) + w[1];

  sha256_round u_round1 (
    .a(r0.a), .b(r0.b), .c(r0.c), .d(r0.d),
    .e(r0.e), .f(r0.f), .g(r0.g), .h(r0.h),
    .k(K[rnd + 6'd1]), .w(w[1]),
    .a_nxt_c(r1.a), .b_nxt_c(r1.b), .c_nxt_c(r1.c), .d_nxt_c(r1.d),
    .e_nxt_c(r1.e), .f_nxt_c(r1.f), .g_nxt_c(r1.g), .h_nxt_c(r1.h)
  );

  always_comb begin
    wk_nxt = r1;
    for (int i = 0; i < 14; i++) w_nxt[i] = w[i+2];
    w_nxt[14] = w16_c;
    w_nxt[15] = w17_c;
  end
`else
  always_comb begin
    wk_nxt = r0;
    for (int i = 0; i < 15; i++) w_nxt[i] = w[i+1];
    w_nxt[15] = w16_c;
  end
`endif

  // Per-word feed-forward of the working variables into the chained hash.
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++)
      h_sum[i*32 +: 32] = hash[i*32 +: 32] + wk[i*32 +: 32];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= LOAD;
      word_cnt  <= 4'd0;
      rnd       <= 6'd0;
      for (int i = 0; i < 16; i++) w[i] <= 32'd0;
      wk        <= '0;
      hash      <= H_IV;
      wr_ready  <= 1'b1;
      blk_ready <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (wr_en) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15]     <= data;
            blk_ready <= 1'b0;
            word_cnt  <= word_cnt + 4'd1;
            if (word_cnt == 4'd15) begin
              word_cnt <= 4'd0;
              rnd      <= 6'd0;
              wk       <= work_t'(hash);
              wr_ready <= 1'b0;
              state    <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          wk  <= wk_nxt;
          for (int i = 0; i < 16; i++) w[i] <= w_nxt[i];
          rnd <= rnd + 6'(ROUND_STEP);
          if (rnd == LAST_RND) state <= FINAL;
        end
        FINAL: begin
          hash      <= h_sum;
          rnd       <= 6'd0;
          blk_ready <= 1'b1;
          wr_ready  <= 1'b1;
          state     <= LOAD;
        end
        default: begin
          wr_ready <= 1'b1;
          state    <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// Self-checking bench for sha256_core with a digest scoreboard.
module tb_sha256_core;

`ifdef SHA256_CORE_TWO_ROUNDS_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif

  localparam logic [255:0] IV  =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] HELLO =
    256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
  localparam logic [255:0] TWO_BLK =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk;
  logic         resetn;
  logic [31:0]  data;
  logic         wr_en;
  logic         wr_ready;
  logic         blk_ready;
  logic [255:0] hash;

  int n_checks = 0;
  int n_fail   = 0;
  logic [255:0] exp_q [$];
  logic [31:0]  blk [16];

  sha256_core dut (
    .clk(clk), .resetn(resetn), .data(data), .wr_en(wr_en),
    .wr_ready(wr_ready), .blk_ready(blk_ready), .hash(hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    wr_en  = 1'b0;
    data   = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
  endtask

  // Drive one word; leaves wr_en high when hold is set for back-to-back writes.
  task automatic write_word(input logic [31:0] d, input bit hold);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!wr_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!wr_ready) begin
      check("wr_ready_wait", 256'(0), 256'(1));
      wr_en = 1'b0;
      return;
    end
    data  = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) wr_en = 1'b0;
  endtask

  task automatic send_block(input string tag, input int gap_max, input bit hold,
                            input bit pulse, input bit wait_done,
                            input bit has_exp, input logic [255:0] exp);
    int n;
    bit done;
    logic [255:0] h_before;
    for (int i = 0; i < 16; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      write_word(blk[i], hold && (i < 15));
    end
    if (has_exp) exp_q.push_back(exp);
    if (!wait_done) return;
    n = 0;
    done = 1'b0;
    h_before = hash;
    while (!done && n < 200) begin
      if (pulse && n == 10) begin
        data  = 32'hdeadbeef;
        wr_en = 1'b1;
      end
      if (pulse && n == 12) wr_en = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (pulse && n == 11) begin
        check({tag, "_busy_wr_ready"}, 256'(wr_ready), 256'(0));
        check({tag, "_busy_hash"}, hash, h_before);
      end
      if (blk_ready) done = 1'b1;
    end
    check({tag, "_latency"}, 256'(n), 256'(LAT));
    check({tag, "_wr_ready_after"}, 256'(wr_ready), 256'(1));
    if (done && exp_q.size() > 0) check({tag, "_digest"}, hash, exp_q.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    wr_en  = 1'b0;
    data   = 32'd0;
    do_reset();
    #1;
    check("reset_hash", hash, IV);
    check("reset_wr_ready", 256'(wr_ready), 256'(1));
    check("reset_blk_ready", 256'(blk_ready), 256'(0));

    // "abc", single block, then idle and start of a following block
    clear_blk();
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    send_block("abc", 0, 1'b0, 1'b0, 1'b1, 1'b1, ABC);
    repeat (5) @(negedge clk);
    check("idle_blk_ready", 256'(blk_ready), 256'(1));
    check("idle_hash", hash, ABC);
    write_word(32'h0, 1'b0);
    check("next_word_blk_ready", 256'(blk_ready), 256'(0));
    check("next_word_wr_ready", 256'(wr_ready), 256'(1));

    // "hello world" with random gaps between words
    do_reset();
    check("reset2_hash", hash, IV);
    clear_blk();
    blk[0]  = 32'h68656c6c;
    blk[1]  = 32'h6f20776f;
    blk[2]  = 32'h726c6480;
    blk[15] = 32'h00000058;
    send_block("hello", 3, 1'b0, 1'b0, 1'b1, 1'b1, HELLO);

    // Two-block message, back-to-back writes, wr_en pulsed while busy
    do_reset();
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    send_block("two_blk1", 0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    clear_blk();
    blk[15] = 32'h000001c0;
    send_block("two_blk2", 0, 1'b1, 1'b0, 1'b1, 1'b1, TWO_BLK);

    // Reset in the middle of COMPUTE, then a clean "abc"
    do_reset();
    clear_blk();
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    send_block("abort", 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (30) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("abort_hash", hash, IV);
    check("abort_wr_ready", 256'(wr_ready), 256'(1));
    check("abort_blk_ready", 256'(blk_ready), 256'(0));
    @(negedge clk);
    resetn = 1'b1;
    send_block("abc_after_abort", 0, 1'b0, 1'b0, 1'b1, 1'b1, ABC);

    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
